// File: rtl/hdmi_line_fetch_ctrl.sv
// Frame-buffer line fetch scheduler for the HDMI pixel path: issues fixed-size read
// bursts one line ahead of active video, paced by free space in the pixel FIFO.
module hdmi_line_fetch_ctrl #(
    parameter int unsigned ADDR_W       = 28,
    parameter int unsigned H_ACTIVE     = 640,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned PIX_PER_BEAT = 16,
    parameter int unsigned BURST_BEATS  = 8,
    parameter int unsigned FIFO_AW      = 6
) (
    input  logic              hdmi_clk_i,
    input  logic              hdmi_rst,
    input  logic              frame_start,
    input  logic              line_start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [FIFO_AW:0]  fifo_level,
    input  logic              pix_pop,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_len,
    input  logic              rd_ack,
    input  logic              rd_valid,
    output logic              fifo_wr,
    output logic [9:0]        line_idx,
    output logic              busy,
    output logic              overrun,
    output logic              underrun,
    input  logic              clr_flags
);

    localparam int unsigned BEATS_LINE  = H_ACTIVE / PIX_PER_BEAT;
    localparam int unsigned BURSTS_LINE = BEATS_LINE / BURST_BEATS;
    localparam int unsigned BURST_W     = (BURSTS_LINE > 1) ? $clog2(BURSTS_LINE) : 1;
    localparam int unsigned BEAT_W      = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
    // Highest FIFO fill that still leaves room for a whole burst.
    localparam int unsigned LEVEL_MAX   = (2 ** FIFO_AW) - BURST_BEATS;

    typedef enum logic [2:0] {StIdle, StArm, StCheck, StReq, StData} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   line_addr_q, line_addr_d;
    logic [ADDR_W-1:0]   pend_base_q, pend_base_d;
    logic [9:0]          line_idx_q, line_idx_d;
    logic [BURST_W-1:0]  burst_q, burst_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                resync_q, resync_d;
    logic                overrun_q, overrun_d;
    logic                underrun_q, underrun_d;

    always_ff @(posedge hdmi_clk_i or posedge hdmi_rst) begin
        if (hdmi_rst) begin
            state_q     <= StIdle;
            line_addr_q <= '0;
            pend_base_q <= '0;
            line_idx_q  <= '0;
            burst_q     <= '0;
            beat_q      <= '0;
            resync_q    <= 1'b0;
            overrun_q   <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_addr_q <= line_addr_d;
            pend_base_q <= pend_base_d;
            line_idx_q  <= line_idx_d;
            burst_q     <= burst_d;
            beat_q      <= beat_d;
            resync_q    <= resync_d;
            overrun_q   <= overrun_d;
            underrun_q  <= underrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        line_addr_d = line_addr_q;
        pend_base_d = pend_base_q;
        line_idx_d  = line_idx_q;
        burst_d     = burst_q;
        beat_d      = beat_q;
        resync_d    = resync_q;
        rd_req      = 1'b0;
        fifo_wr     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (frame_start) begin
                    line_addr_d = base_addr;
                    line_idx_d  = '0;
                    state_d     = StArm;
                end
            end
            StArm, StCheck: begin
                if (frame_start) begin
                    line_addr_d = base_addr;
                    line_idx_d  = '0;
                    state_d     = StArm;
                end else if (state_q == StArm) begin
                    if (line_start) begin
                        burst_d = '0;
                        state_d = StCheck;
                    end
                end else if (fifo_level <= (FIFO_AW + 1)'(LEVEL_MAX)) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                rd_req = 1'b1;
                if (frame_start) begin
                    resync_d    = 1'b1;
                    pend_base_d = base_addr;
                end
                if (rd_ack) begin
                    beat_d  = '0;
                    state_d = StData;
                end
            end
            StData: begin
                fifo_wr = rd_valid;
                if (frame_start) begin
                    resync_d    = 1'b1;
                    pend_base_d = base_addr;
                end
                if (rd_valid) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == BEAT_W'(BURST_BEATS - 1)) begin
                        // A pending resync takes precedence over normal line progression.
                        if (resync_d) begin
                            resync_d    = 1'b0;
                            line_addr_d = pend_base_d;
                            line_idx_d  = '0;
                            state_d     = StArm;
                        end else if (burst_q != BURST_W'(BURSTS_LINE - 1)) begin
                            burst_d = burst_q + 1'b1;
                            state_d = StCheck;
                        end else begin
                            line_addr_d = line_addr_q + ADDR_W'(BEATS_LINE);
                            if (line_idx_q == 10'(V_ACTIVE - 1)) begin
                                line_idx_d = '0;
                                state_d    = StIdle;
                            end else begin
                                line_idx_d = line_idx_q + 10'd1;
                                state_d    = StArm;
                            end
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        overrun_d  = (line_start && (state_q != StArm)) || (overrun_q && !clr_flags);
        underrun_d = (pix_pop && (fifo_level == '0)) || (underrun_q && !clr_flags);
    end

    assign rd_addr  = line_addr_q + ADDR_W'(burst_q) * ADDR_W'(BURST_BEATS);
    assign rd_len   = 8'(BURST_BEATS);
    assign line_idx = line_idx_q;
    assign busy     = (state_q == StCheck) || (state_q == StReq) || (state_q == StData);
    assign overrun  = overrun_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_hdmi_line_fetch_ctrl.sv
// Directed self-checking bench for hdmi_line_fetch_ctrl; each task drives one scenario
// and compares outputs against hand-computed values.
module tb_hdmi_line_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start, line_start, pix_pop, rd_ack, rd_valid, clr_flags;
    logic [27:0] base_addr;
    logic [6:0]  fifo_level;
    logic        rd_req, fifo_wr, busy, overrun, underrun;
    logic [27:0] rd_addr;
    logic [7:0]  rd_len;
    logic [9:0]  line_idx;

    int tests = 0;
    int fails = 0;
    bit stuck = 0;

    always #5 clk = ~clk;

    hdmi_line_fetch_ctrl dut (
        .hdmi_clk_i (clk),
        .hdmi_rst   (rst),
        .frame_start(frame_start),
        .line_start (line_start),
        .base_addr  (base_addr),
        .fifo_level (fifo_level),
        .pix_pop    (pix_pop),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_len     (rd_len),
        .rd_ack     (rd_ack),
        .rd_valid   (rd_valid),
        .fifo_wr    (fifo_wr),
        .line_idx   (line_idx),
        .busy       (busy),
        .overrun    (overrun),
        .underrun   (underrun),
        .clr_flags  (clr_flags)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_line();
        line_start = 1'b1;
        step();
        line_start = 1'b0;
    endtask

    // Waits for a request, acks it after ack_dly cycles, then returns 8 beats.
    task automatic serve_burst(input logic [27:0] exp_addr, input int ack_dly,
                               input int fs_beat, input logic [27:0] fs_base,
                               output int wr_cnt);
        int waitc = 0;
        int req_cycles = 0;
        bit addr_ok = 1;
        wr_cnt = 0;
        if (stuck) return;
        #1;
        while (!rd_req && waitc < 200) begin
            step();
            waitc++;
        end
        tests++;
        if (rd_req !== 1'b1) begin
            fails++;
            stuck = 1;
            $display("FAIL req_timeout: rd_req=%b required 1 (addr %0h)", rd_req, exp_addr);
            return;
        end
        for (int k = 0; k <= ack_dly; k++) begin
            rd_ack = (k == ack_dly);
            #1;
            if (rd_req === 1'b1) req_cycles++;
            if (rd_addr !== exp_addr) addr_ok = 0;
            step();
        end
        rd_ack = 1'b0;
        #1;
        if (rd_req === 1'b1) req_cycles++;
        tests++;
        if (!addr_ok) begin
            fails++;
            $display("FAIL rd_addr: got %0h required %0h (held)", rd_addr, exp_addr);
        end
        tests++;
        if (req_cycles != ack_dly + 1) begin
            fails++;
            $display("FAIL req_len: rd_req high %0d cycles required %0d", req_cycles, ack_dly + 1);
        end
        for (int b = 0; b < 8; b++) begin
            rd_valid = 1'b1;
            if (b == fs_beat) begin
                frame_start = 1'b1;
                base_addr   = fs_base;
            end
            #1;
            if (fifo_wr === 1'b1) wr_cnt++;
            step();
            frame_start = 1'b0;
        end
        rd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        frame_start = 0; line_start = 0; pix_pop = 0; rd_ack = 0; rd_valid = 0; clr_flags = 0;
        base_addr = '0; fifo_level = '0;
        step();
        step();
        tests++;
        if ({rd_req, fifo_wr, busy, overrun, underrun} !== 5'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b required 00000",
                     {rd_req, fifo_wr, busy, overrun, underrun});
        end
        tests++;
        if (rd_addr !== 28'h0 || line_idx !== 10'd0) begin
            fails++;
            $display("FAIL reset_addr: rd_addr=%0h line_idx=%0d required 0/0", rd_addr, line_idx);
        end
        tests++;
        if (rd_len !== 8'd8) begin
            fails++;
            $display("FAIL rd_len: got %0d required 8", rd_len);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_line_fetch();
        int w, total = 0;
        base_addr = 28'h100;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        base_addr = 28'h0abc;
        tests++;
        if (busy !== 1'b0 || line_idx !== 10'd0) begin
            fails++;
            $display("FAIL arm_state: busy=%b line_idx=%0d required 0/0", busy, line_idx);
        end
        pulse_line();
        for (int b = 0; b < 5; b++) begin
            serve_burst(28'h100 + 28'(b * 8), 0, -1, 28'h0, w);
            total += w;
        end
        tests++;
        if (total != 40) begin
            fails++;
            $display("FAIL line_wr_count: got %0d required 40", total);
        end
        tests++;
        if (line_idx !== 10'd1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL line_end: line_idx=%0d busy=%b required 1/0", line_idx, busy);
        end
    endtask

    task automatic test_fifo_pacing();
        int w;
        bit quiet = 1;
        fifo_level = 7'd60;
        pulse_line();
        for (int i = 0; i < 6; i++) begin
            #1;
            if (rd_req !== 1'b0 || busy !== 1'b1) quiet = 0;
            step();
        end
        tests++;
        if (!quiet) begin
            fails++;
            $display("FAIL check_hold: rd_req=%b busy=%b required 0/1 at level 60", rd_req, busy);
        end
        fifo_level = 7'd56;
        #1;
        tests++;
        if (rd_req !== 1'b0) begin
            fails++;
            $display("FAIL req_early: rd_req=%b required 0", rd_req);
        end
        step();
        tests++;
        if (rd_req !== 1'b1) begin
            fails++;
            $display("FAIL req_after_level: rd_req=%b required 1", rd_req);
        end
        for (int b = 0; b < 5; b++) serve_burst(28'h128 + 28'(b * 8), 0, -1, 28'h0, w);
        tests++;
        if (line_idx !== 10'd2) begin
            fails++;
            $display("FAIL pacing_line_idx: got %0d required 2", line_idx);
        end
        fifo_level = '0;
    endtask

    task automatic test_ack_delay();
        int w;
        pulse_line();
        serve_burst(28'h150, 7, -1, 28'h0, w);
        for (int b = 1; b < 5; b++) serve_burst(28'h150 + 28'(b * 8), 0, -1, 28'h0, w);
        tests++;
        if (line_idx !== 10'd3) begin
            fails++;
            $display("FAIL ack_line_idx: got %0d required 3", line_idx);
        end
    endtask

    task automatic test_frame_start_mid_data();
        int w;
        pulse_line();
        serve_burst(28'h178, 0, 3, 28'h4000, w);
        tests++;
        if (w != 8) begin
            fails++;
            $display("FAIL resync_beats: got %0d required 8", w);
        end
        tests++;
        if (busy !== 1'b0 || line_idx !== 10'd0) begin
            fails++;
            $display("FAIL resync_state: busy=%b line_idx=%0d required 0/0", busy, line_idx);
        end
        pulse_line();
        serve_burst(28'h4000, 0, -1, 28'h0, w);
        // Now in CHECK for burst 1; hold it there and resync again.
        fifo_level = 7'd60;
        step();
        step();
        tests++;
        if (rd_req !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL check_wait: rd_req=%b busy=%b required 0/1", rd_req, busy);
        end
        base_addr = 28'h200;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        tests++;
        if (busy !== 1'b0 || line_idx !== 10'd0) begin
            fails++;
            $display("FAIL check_resync: busy=%b line_idx=%0d required 0/0", busy, line_idx);
        end
        fifo_level = '0;
    endtask

    task automatic test_full_frame();
        int w;
        for (int ln = 0; ln < 480; ln++) begin
            if (stuck) break;
            pulse_line();
            for (int b = 0; b < 5; b++)
                serve_burst(28'h200 + 28'(ln * 40 + b * 8), 0, -1, 28'h0, w);
        end
        tests++;
        if (busy !== 1'b0 || overrun !== 1'b0) begin
            fails++;
            $display("FAIL frame_end: busy=%b overrun=%b required 0/0", busy, overrun);
        end
        step();
        step();
        tests++;
        if (rd_req !== 1'b0) begin
            fails++;
            $display("FAIL idle_no_req: rd_req=%b required 0", rd_req);
        end
        pulse_line();
        tests++;
        if (overrun !== 1'b1) begin
            fails++;
            $display("FAIL overrun_idle: got %b required 1", overrun);
        end
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        tests++;
        if (overrun !== 1'b0) begin
            fails++;
            $display("FAIL overrun_clr: got %b required 0", overrun);
        end
    endtask

    task automatic test_underrun();
        fifo_level = 7'd5;
        pix_pop = 1'b1;
        step();
        tests++;
        if (underrun !== 1'b0) begin
            fails++;
            $display("FAIL underrun_nonempty: got %b required 0", underrun);
        end
        fifo_level = 7'd0;
        step();
        pix_pop = 1'b0;
        tests++;
        if (underrun !== 1'b1) begin
            fails++;
            $display("FAIL underrun_set: got %b required 1", underrun);
        end
        clr_flags = 1'b1;
        step();
        tests++;
        if (underrun !== 1'b0) begin
            fails++;
            $display("FAIL underrun_clr: got %b required 0", underrun);
        end
        pix_pop = 1'b1;
        step();
        pix_pop = 1'b0;
        clr_flags = 1'b0;
        tests++;
        if (underrun !== 1'b1) begin
            fails++;
            $display("FAIL underrun_set_wins: got %b required 1", underrun);
        end
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        int waitc = 0;
        bit dropped = 1;
        base_addr = 28'h900;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        pulse_line();
        while (!rd_req && waitc < 50) begin
            step();
            waitc++;
        end
        tests++;
        if (rd_req !== 1'b1 || rd_addr !== 28'h900) begin
            fails++;
            $display("FAIL rst_burst_req: rd_req=%b rd_addr=%0h required 1/900", rd_req, rd_addr);
        end
        rd_ack = 1'b1;
        step();
        rd_ack = 1'b0;
        rd_valid = 1'b1;
        step();
        step();
        #1;
        rst = 1'b1;
        #1;
        tests++;
        if ({rd_req, fifo_wr, busy} !== 3'b0 || rd_addr !== 28'h0 || line_idx !== 10'd0) begin
            fails++;
            $display("FAIL async_reset: req/wr/busy=%b rd_addr=%0h line_idx=%0d required 000/0/0",
                     {rd_req, fifo_wr, busy}, rd_addr, line_idx);
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (fifo_wr !== 1'b0 || busy !== 1'b0) dropped = 0;
        end
        rd_valid = 1'b0;
        tests++;
        if (!dropped) begin
            fails++;
            $display("FAIL late_beats: fifo_wr=%b busy=%b required 0/0", fifo_wr, busy);
        end
    endtask

    initial begin
        test_reset();
        test_line_fetch();
        test_fifo_pacing();
        test_ack_delay();
        test_frame_start_mid_data();
        test_full_frame();
        test_underrun();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
